// File: rtl/out_uart_pkg.sv
// Shared types and constants for the output-register UART transmitter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
// Optional feature macro: OUT_UART_PARITY_EN (adds an even-parity bit per frame).
package out_uart_pkg;

    // Transmitter states. PARITY is only entered when OUT_UART_PARITY_EN is defined.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int BYTE_BITS = 8;

    // Line bits per serialised byte: start + 8 data (+ parity) + stop.
    function automatic int frame_bits();
`ifdef OUT_UART_PARITY_EN
        return BYTE_BITS + 3;
`else
        return BYTE_BITS + 2;
`endif
    endfunction

endpackage

// File: rtl/Sync_Fifo.sv
// Generic synchronous FIFO with occupancy count; combinational read of the head entry.
// Latency: a pushed word is visible at rd_data the cycle after the push edge.
// Backpressure: none internally; the caller must not push when full or pop when empty.
// Ports: clk, rst_n (async active-low); push/wr_data write side; pop/rd_data read side;
//        full, empty and count (log2(DEPTH)+1 bits) status.
module Sync_Fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_q;

    // Pointers are exactly log2(DEPTH) bits so they wrap without explicit compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; contents are only meaningful below count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];
    assign count   = count_q;
    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));

endmodule

// File: rtl/out_uart_tx.sv
// Serialises words written to the CPU Out register as UART frames, low byte first.
// Latency: push into an idle, empty unit -> o_tx start bit one cycle later.
// Backpressure: none; the CPU never stalls, a write into a full FIFO is dropped and o_overflow latches.
// Ports: clk, rst_n (async active-low); clk_en qualifies i_load_enable/i_load_data;
//        o_tx serial line (idle high); o_busy, o_full, o_overflow (sticky) status.
// Optional feature macro: OUT_UART_PARITY_EN (even-parity bit between data and stop).
module out_uart_tx
    import out_uart_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_en,
    input  logic             i_load_enable,
    input  logic [WIDTH-1:0] i_load_data,
    output logic             o_tx,
    output logic             o_busy,
    output logic             o_full,
    output logic             o_overflow
);

    localparam int NBYTES = WIDTH / BYTE_BITS;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NBYTES - 1);

    state_t             state_q, state_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [BYTE_W-1:0]  byte_q, byte_d;
    logic [WIDTH-1:0]   word_q, word_d;
    logic               tx_q, tx_d;
    logic               ovf_q;
    logic               baud_end;

    logic               wr_req;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [WIDTH-1:0]   fifo_rd_data;

    // Fullness is judged on the pre-edge count, so a same-edge pop never rescues a write.
    assign wr_req = clk_en & i_load_enable;
    assign push   = wr_req & ~fifo_full;

    Sync_Fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .wr_data (i_load_data),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign baud_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        word_d  = word_q;
        pop     = 1'b0;
        tx_d    = 1'b1;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    word_d  = fifo_rd_data;
                    byte_d  = '0;
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
`ifdef OUT_UART_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`ifdef OUT_UART_PARITY_EN
            PARITY: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`endif
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    // Remaining bytes of the word follow with no idle gap;
                    // the next byte is brought down into the low lane.
                    if (byte_q != BYTE_LAST) begin
                        byte_d  = byte_q + 1'b1;
                        word_d  = word_q >> BYTE_BITS;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // o_tx is registered, so it is computed from the state being entered.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = word_d[bit_d];
`ifdef OUT_UART_PARITY_EN
            PARITY:  tx_d = ^word_d[BYTE_BITS-1:0];
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            word_q  <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            word_q  <= word_d;
            tx_q    <= tx_d;
            if (wr_req && fifo_full) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign o_tx       = tx_q;
    assign o_busy     = (state_q != IDLE) | (fifo_count != '0);
    assign o_full     = fifo_full;
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_out_uart_tx.sv
// Bench for out_uart_tx: line-level queue model, per-cycle compare, UART receiver, directed + random stimulus.
// Optional feature macro: OUT_UART_PARITY_EN (model and literals follow it).
module tb_out_uart_tx;
    import out_uart_pkg::*;

    localparam int WIDTH = 16;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int NB    = WIDTH / 8;
    localparam int FB    = frame_bits();
    localparam int WC    = NB * FB * CPB;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clk_en;
    logic             i_load_enable;
    logic [WIDTH-1:0] i_load_data;
    logic             o_tx;
    logic             o_busy;
    logic             o_full;
    logic             o_overflow;

    out_uart_tx #(
        .WIDTH        (WIDTH),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clk_en        (clk_en),
        .i_load_enable (i_load_enable),
        .i_load_data   (i_load_data),
        .o_tx          (o_tx),
        .o_busy        (o_busy),
        .o_full        (o_full),
        .o_overflow    (o_overflow)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // m_line holds the expected line level for every upcoming cycle of the frames in flight.
    logic [WIDTH-1:0] m_fifo[$];
    bit               m_line[$];
    bit               m_ovf;
    logic [WIDTH-1:0] m_w;
    logic [7:0]       m_b;
    bit               m_pre_full;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_fifo.delete();
            m_line.delete();
            m_ovf = 1'b0;
        end else begin
            m_pre_full = (m_fifo.size() == DEPTH);
            if (m_line.size() != 0) begin
                void'(m_line.pop_front());
            end else if (m_fifo.size() != 0) begin
                m_w = m_fifo.pop_front();
                for (int j = 0; j < NB; j++) begin
                    m_b = m_w[8*j +: 8];
                    repeat (CPB) m_line.push_back(1'b0);
                    for (int k = 0; k < 8; k++) repeat (CPB) m_line.push_back(m_b[k]);
`ifdef OUT_UART_PARITY_EN
                    repeat (CPB) m_line.push_back(^m_b);
`endif
                    repeat (CPB) m_line.push_back(1'b1);
                end
            end
            if (clk_en && i_load_enable) begin
                if (m_pre_full) m_ovf = 1'b1;
                else            m_fifo.push_back(i_load_data);
            end
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
        end
    endtask

    bit         rx_act;
    int         rx_t;
    logic [7:0] rx_byte;
    logic [7:0] rx_bytes[$];
    bit         rec[$];
    int         lit[2*FB];

    task automatic wait_drain(input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (!o_busy && !rx_act) done = 1'b1;
        end
        chk("drain_in_budget", done, 1);
    endtask

    task automatic push_word(input logic [WIDTH-1:0] w);
        clk_en = 1'b1; i_load_enable = 1'b1; i_load_data = w;
        @(negedge clk);
        i_load_enable = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; clk_en = 1'b0; i_load_enable = 1'b0; i_load_data = '0;
        rx_act = 1'b0; rx_t = 0; rx_byte = '0;

        fork
            forever begin
                @(negedge clk);
                if (rst_n) begin
                    chk("cycle{tx,busy,full,ovf}", {o_tx, o_busy, o_full, o_overflow},
                        {(m_line.size() != 0) ? m_line[0] : 1'b1,
                         (m_line.size() != 0) || (m_fifo.size() != 0),
                         m_fifo.size() == DEPTH, m_ovf});
                end
            end
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    rx_act = 1'b0;
                end else if (!rx_act) begin
                    if (o_tx == 1'b0) begin rx_act = 1'b1; rx_t = 0; rx_byte = '0; end
                end else begin
                    rx_t++;
                    if (rx_t % CPB == CPB / 2) begin
                        if (rx_t / CPB >= 1 && rx_t / CPB <= 8) rx_byte[rx_t / CPB - 1] = o_tx;
`ifdef OUT_UART_PARITY_EN
                        if (rx_t / CPB == 9) chk("rx_parity", o_tx, ^rx_byte);
`endif
                    end
                    if (rx_t == FB * CPB - 1) begin
                        rx_act = 1'b0;
                        rx_bytes.push_back(rx_byte);
                    end
                end
            end
        join_none

        // Reset state
        #12;
        chk("rst_tx", o_tx, 1);
        chk("rst_busy", o_busy, 0);
        chk("rst_full", o_full, 0);
        chk("rst_ovf", o_overflow, 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        // Single word, literal line pattern
`ifdef OUT_UART_PARITY_EN
        lit = '{0, 1,1,1,0,0,0,0,0, 1, 1,  0, 1,1,0,0,0,0,0,0, 0, 1};
        push_word(16'h0307);
`else
        lit = '{0, 0,0,1,0,1,1,0,0, 1,  0, 0,1,0,0,1,0,0,0, 1};
        push_word(16'h1234);
`endif
        chk("tx_high_at_E", o_tx, 1);
        chk("busy_after_push", o_busy, 1);
        rec.delete();
        for (int i = 0; i < WC; i++) begin
            @(negedge clk);
            rec.push_back(o_tx);
        end
        chk("tx_fall_E+1", rec[0], 0);
        for (int b = 0; b < 2 * FB; b++) chk("single_bit", rec[b * CPB + CPB / 2], lit[b]);
        @(negedge clk);
        chk("single_busy_done", o_busy, 0);
        chk("single_ovf", o_overflow, 0);

        // Gated strobe
        clk_en = 1'b0; i_load_enable = 1'b1;
        repeat (10) begin
            i_load_data = WIDTH'($urandom);
            @(negedge clk);
            chk("gated_tx", o_tx, 1);
            chk("gated_busy", o_busy, 0);
        end
        i_load_enable = 1'b0; clk_en = 1'b1;

        // Overflow
        rx_bytes.delete();
        for (int i = 1; i <= 6; i++) begin
            i_load_enable = 1'b1; i_load_data = WIDTH'(i);
            @(negedge clk);
            if (i == 4) chk("full_before_5th", o_full, 0);
            if (i == 5) chk("full_after_5th", o_full, 1);
            if (i == 6) chk("ovf_after_6th", o_overflow, 1);
        end
        i_load_enable = 1'b0;
        wait_drain(2000);
        chk("ovf_rx_count", rx_bytes.size(), 2 * 5);
        for (int w = 0; w < 5 && rx_bytes.size() == 10; w++)
            chk("ovf_rx_word", {rx_bytes[2*w+1], rx_bytes[2*w]}, w + 1);

        // Back-to-back
        rx_bytes.delete();
        i_load_enable = 1'b1; i_load_data = 16'hAAAA;
        @(negedge clk);
        i_load_data = 16'h5555;
        @(negedge clk);
        i_load_enable = 1'b0;
        rec.delete();
        rec.push_back(o_tx);
        for (int i = 0; i < WC + 4; i++) begin
            @(negedge clk);
            rec.push_back(o_tx);
        end
        chk("b2b_stop1", rec[FB * CPB - 1], 1);
        chk("b2b_no_gap", rec[FB * CPB], 0);
        chk("b2b_gap_high", rec[WC], 1);
        chk("b2b_next_start", rec[WC + 1], 0);
        wait_drain(1000);
        chk("b2b_rx_count", rx_bytes.size(), 4);
        if (rx_bytes.size() == 4) begin
            chk("b2b_word0", {rx_bytes[1], rx_bytes[0]}, 16'hAAAA);
            chk("b2b_word1", {rx_bytes[3], rx_bytes[2]}, 16'h5555);
        end

        // Reset during DATA bit 3
        push_word(16'h0000);
        repeat (18) @(negedge clk);
        chk("data_bit3_low", o_tx, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_tx", o_tx, 1);
        chk("midrst_busy", o_busy, 0);
        chk("midrst_full", o_full, 0);
        chk("midrst_ovf", o_overflow, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        rx_bytes.delete();
        @(negedge clk);
        push_word(16'h00FF);
        wait_drain(1000);
        chk("post_rst_rx_count", rx_bytes.size(), 2);
        if (rx_bytes.size() == 2) chk("post_rst_word", {rx_bytes[1], rx_bytes[0]}, 16'h00FF);

        // Random traffic against the model
        repeat (2500) begin
            clk_en        = ($urandom_range(0, 3) != 0);
            i_load_enable = ($urandom_range(0, 9) == 0);
            i_load_data   = WIDTH'($urandom);
            @(negedge clk);
        end
        i_load_enable = 1'b0;
        wait_drain(2000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
